// File: rtl/util_pkg.sv
// Shared pipeline utility types: state encoding for the skid pipeline register.
package util_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline register with a 1-entry skid buffer; ready is registered so no comb path crosses stages.
// Latency 1 cycle, 1 transfer/cycle; in_ready drops only when both main and skid hold data.
module pipe_skid_reg
    import util_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             in_f, out_f;

    assign out_valid = (state != SKID_EMPTY);
    assign in_ready  = (state != SKID_FULL);
    assign out_data  = main_q;

    assign in_f  = in_valid & in_ready;
    assign out_f = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        unique case (state)
            SKID_EMPTY: begin
                if (in_f) begin
                    main_nxt  = in_data;
                    state_nxt = SKID_BUSY;
                end
            end
            SKID_BUSY: begin
                if (in_f && out_f) begin
                    main_nxt = in_data;
                end else if (in_f) begin
                    skid_nxt  = in_data;
                    state_nxt = SKID_FULL;
                end else if (out_f) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so the skid entry drains into main with no new input.
                if (out_f) begin
                    main_nxt  = skid_q;
                    state_nxt = SKID_BUSY;
                end
            end
            default: state_nxt = SKID_EMPTY;
        endcase
        // Squash discards anything accepted this cycle; a same-cycle output was already delivered.
        if (flush) begin
            state_nxt = SKID_EMPTY;
            main_nxt  = RESET_VAL;
            skid_nxt  = RESET_VAL;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= SKID_EMPTY;
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

endmodule
